alu_sequencer: RTL and testbench

Instruction-issuing initiator that drives the 4-bit ALU's operand, mode, enable and carry-in inputs, then captures its 8-bit result and 4-bit flags. Holds an 8 x 4-bit operand register file and a flag register, and feeds the stored carry back into chained add/subtract operations. Sits between the instruction source (valid/ready handshake) and one ALU instance.

---
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for a 4-bit ALU: reads operands from an 8 x 4-bit register file,
// drives the ALU, captures its result and flags, and writes the result back.
module alu_sequencer #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [3:0]    i_mode,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    input  logic [AW-1:0] i_rd,
    input  logic          i_use_c,
    input  logic          i_wide,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [3:0]    i_ld_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [3:0]    o_rd_data,
    output logic [3:0]    o_alu_E,
    output logic [3:0]    o_alu_mode,
    output logic          o_alu_cflag,
    output logic [3:0]    o_alu_op1,
    output logic [3:0]    o_alu_op2,
    input  logic [7:0]    i_alu_result,
    input  logic [3:0]    i_alu_flags,
    output logic [7:0]    o_result,
    output logic [3:0]    o_flags,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          load;
    logic [3:0]    regs [NREG];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_hi;
    logic          wide_q;

    // A load owns the cycle, so an instruction can never be accepted alongside it.
    assign o_ready = (state_q == S_IDLE) && !i_ld_en;
    assign accept  = i_valid && o_ready;
    assign load    = (state_q == S_IDLE) && i_ld_en;

    // The high nibble destination wraps naturally in AW bits.
    assign rd_hi     = rd_q + AW'(1);
    assign o_rd_data = regs[i_rd_addr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        o_alu_E = 4'h0;
        o_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_alu_E = 4'hF;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_alu_E = 4'hF;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the register file is cleared on reset, which keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 4'h0;
            end
            o_alu_mode  <= 4'h0;
            o_alu_cflag <= 1'b0;
            o_alu_op1   <= 4'h0;
            o_alu_op2   <= 4'h0;
            o_result    <= 8'h00;
            o_flags     <= 4'h0;
            rd_q        <= '0;
            wide_q      <= 1'b0;
        end else begin
            if (accept) begin
                o_alu_op1   <= regs[i_rs1];
                o_alu_op2   <= regs[i_rs2];
                o_alu_mode  <= i_mode;
                o_alu_cflag <= i_use_c & o_flags[3];
                rd_q        <= i_rd;
                wide_q      <= i_wide;
            end

            if (state_q == S_CAPTURE) begin
                o_result <= i_alu_result;
                o_flags  <= i_alu_flags;
            end

            // The high-nibble write comes second so it wins if both target one register.
            if (state_q == S_WRITE) begin
                regs[rd_q] <= o_result[3:0];
                if (wide_q) begin
                    regs[rd_hi] <= o_result[7:4];
                end
            end

            if (load) begin
                regs[i_ld_addr] <= i_ld_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; the bench plays the ALU and answers each issued
// operation with hand-computed result/flag constants.
module tb_alu_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [3:0] i_mode = 4'h0;
    logic [2:0] i_rs1 = 3'd0;
    logic [2:0] i_rs2 = 3'd0;
    logic [2:0] i_rd = 3'd0;
    logic       i_use_c = 1'b0;
    logic       i_wide = 1'b0;
    logic       i_ld_en = 1'b0;
    logic [2:0] i_ld_addr = 3'd0;
    logic [3:0] i_ld_data = 4'h0;
    logic [2:0] i_rd_addr = 3'd0;
    logic [3:0] o_rd_data;
    logic [3:0] o_alu_E;
    logic [3:0] o_alu_mode;
    logic       o_alu_cflag;
    logic [3:0] o_alu_op1;
    logic [3:0] o_alu_op2;
    logic [7:0] i_alu_result = 8'hC3;
    logic [3:0] i_alu_flags = 4'h6;
    logic [7:0] o_result;
    logic [3:0] o_flags;
    logic       o_done;

    int checks = 0;
    int failures = 0;

    alu_sequencer #(.NREG(8), .AW(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_use_c(i_use_c), .i_wide(i_wide), .i_ld_en(i_ld_en),
        .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_alu_E(o_alu_E), .o_alu_mode(o_alu_mode),
        .o_alu_cflag(o_alu_cflag), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
        .i_alu_result(i_alu_result), .i_alu_flags(i_alu_flags),
        .o_result(o_result), .o_flags(o_flags), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [3:0] exp);
        i_rd_addr = addr;
        #1;
        check(tag, {4'h0, o_rd_data}, {4'h0, exp});
    endtask

    task automatic load_reg(input logic [2:0] addr, input logic [3:0] data);
        @(negedge i_clk);
        i_ld_en   = 1'b1;
        i_ld_addr = addr;
        i_ld_data = data;
        @(posedge i_clk);
        #1;
        i_ld_en = 1'b0;
    endtask

    // Issue one instruction from IDLE and follow it cycle by cycle to N+4.
    task automatic run_op(input string tag, input logic [3:0] mode,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                          input logic use_c, input logic wide,
                          input logic [3:0] e_op1, input logic [3:0] e_op2, input logic e_cin,
                          input logic [7:0] alu_res, input logic [3:0] alu_flg);
        @(negedge i_clk);
        i_alu_result = 8'hC3;
        i_alu_flags  = 4'h6;
        i_valid = 1'b1; i_mode = mode; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
        i_use_c = use_c; i_wide = wide;
        #1 check({tag, "_ready"}, {7'h0, o_ready}, 8'h01);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check({tag, "_op1"}, {4'h0, o_alu_op1}, {4'h0, e_op1});
        check({tag, "_op2"}, {4'h0, o_alu_op2}, {4'h0, e_op2});
        check({tag, "_cin"}, {7'h0, o_alu_cflag}, {7'h0, e_cin});
        check({tag, "_mode"}, {4'h0, o_alu_mode}, {4'h0, mode});
        check({tag, "_en1"}, {4'h0, o_alu_E}, 8'h0F);
        check({tag, "_done1"}, {7'h0, o_done}, 8'h00);
        i_alu_result = alu_res;
        i_alu_flags  = alu_flg;
        @(posedge i_clk);
        #1;
        check({tag, "_en2"}, {4'h0, o_alu_E}, 8'h0F);
        check({tag, "_done2"}, {7'h0, o_done}, 8'h00);
        @(posedge i_clk);
        #1;
        i_alu_result = 8'hC3;
        i_alu_flags  = 4'h6;
        check({tag, "_done3"}, {7'h0, o_done}, 8'h01);
        check({tag, "_en3"}, {4'h0, o_alu_E}, 8'h00);
        check({tag, "_res"}, o_result, alu_res);
        check({tag, "_flg"}, {4'h0, o_flags}, {4'h0, alu_flg});
        @(posedge i_clk);
        #1;
        check({tag, "_done4"}, {7'h0, o_done}, 8'h00);
        check({tag, "_ready4"}, {7'h0, o_ready}, 8'h01);
    endtask

    logic [7:0] sweep_res [14] = '{8'h00, 8'h0F, 8'h0F, 8'h05, 8'h14, 8'h05, 8'h0B,
                                   8'h09, 8'h32, 8'h0A, 8'h05, 8'h0F, 8'hA5, 8'h00};
    logic [3:0] sweep_flg [14] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2,
                                   4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h1};

    initial begin
        // Reset state
        i_rst = 1'b1;
        #12;
        check("rst_ready", {7'h0, o_ready}, 8'h01);
        check("rst_E", {4'h0, o_alu_E}, 8'h00);
        check("rst_result", o_result, 8'h00);
        check("rst_flags", {4'h0, o_flags}, 8'h00);
        check("rst_op", {o_alu_op1, o_alu_op2}, 8'h00);
        check("rst_mode_cin", {3'h0, o_alu_cflag, o_alu_mode}, 8'h00);
        check("rst_done", {7'h0, o_done}, 8'h00);
        check_reg("rst_r0", 3'd0, 4'h0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Wide add with carry out
        load_reg(3'd0, 4'hF);
        load_reg(3'd1, 4'h1);
        check_reg("ld_r0", 3'd0, 4'hF);
        run_op("wadd", 4'b0000, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 8'h10, 4'b1000);
        check_reg("wadd_r2", 3'd2, 4'h0);
        check_reg("wadd_r3", 3'd3, 4'h1);

        // Carry chain from the stored carry flag
        run_op("chain", 4'b0000, 3'd3, 3'd3, 3'd4, 1'b1, 1'b0, 4'h1, 4'h1, 1'b1, 8'h03, 4'b0000);
        check_reg("chain_r4", 3'd4, 4'h3);

        // Subtract with borrow; wide write of rd=7 wraps to r0
        load_reg(3'd5, 4'h3);
        load_reg(3'd6, 4'h5);
        load_reg(3'd0, 4'h0);
        run_op("sub", 4'b0001, 3'd5, 3'd6, 3'd7, 1'b0, 1'b1, 4'h3, 4'h5, 1'b0, 8'hFE, 4'b1110);
        check_reg("sub_r7", 3'd7, 4'hE);
        check_reg("sub_r0_wrap", 3'd0, 4'hF);

        // Handshake: valid held while a load blocks ready; load ignored outside IDLE
        @(negedge i_clk);
        i_valid = 1'b1; i_mode = 4'b0010; i_rs1 = 3'd6; i_rs2 = 3'd5; i_rd = 3'd1;
        i_use_c = 1'b0; i_wide = 1'b0;
        i_ld_en = 1'b1; i_ld_addr = 3'd6; i_ld_data = 4'h9;
        #1 check("hs_ready_low", {7'h0, o_ready}, 8'h00);
        @(posedge i_clk);
        #1;
        check("hs_no_accept", {4'h0, o_alu_E}, 8'h00);
        i_ld_en = 1'b0;
        #1 check("hs_ready_high", {7'h0, o_ready}, 8'h01);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("hs_issue_E", {4'h0, o_alu_E}, 8'h0F);
        check("hs_op1", {4'h0, o_alu_op1}, 8'h09);
        check("hs_cin", {7'h0, o_alu_cflag}, 8'h00);
        i_ld_en = 1'b1; i_ld_addr = 3'd6; i_ld_data = 4'h2;
        i_alu_result = 8'h01; i_alu_flags = 4'h0;
        @(posedge i_clk);
        #1;
        i_ld_en = 1'b0;
        check("hs_done_n2", {7'h0, o_done}, 8'h00);
        @(posedge i_clk);
        #1;
        check("hs_done_n3", {7'h0, o_done}, 8'h01);
        @(posedge i_clk);
        #1;
        check_reg("hs_r6_kept", 3'd6, 4'h9);
        check_reg("hs_r1", 3'd1, 4'h1);

        // Mode sweep with op1=A, op2=5, wide write into r5/r6
        load_reg(3'd2, 4'hA);
        load_reg(3'd3, 4'h5);
        for (int m = 2; m < 16; m++) begin
            run_op($sformatf("mode%0h", m), 4'(m), 3'd2, 3'd3, 3'd5, 1'b0, 1'b1,
                   4'hA, 4'h5, 1'b0, sweep_res[m-2], sweep_flg[m-2]);
            check_reg($sformatf("mode%0h_rd", m), 3'd5, sweep_res[m-2][3:0]);
            check_reg($sformatf("mode%0h_rd1", m), 3'd6, sweep_res[m-2][7:4]);
        end
        check("sweep_zero_flag", {7'h0, o_flags[0]}, 8'h01);

        // Reset in CAPTURE aborts the instruction
        @(negedge i_clk);
        i_valid = 1'b1; i_mode = 4'b0000; i_rs1 = 3'd2; i_rs2 = 3'd3; i_rd = 3'd0;
        i_use_c = 1'b0; i_wide = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_alu_result = 8'h7F; i_alu_flags = 4'h2;
        @(posedge i_clk);
        #1;
        check("abort_in_capture", {4'h0, o_alu_E}, 8'h0F);
        i_rst = 1'b1;
        #1;
        check("abort_E", {4'h0, o_alu_E}, 8'h00);
        check("abort_result", o_result, 8'h00);
        check("abort_flags", {4'h0, o_flags}, 8'h00);
        check("abort_op", {o_alu_op1, o_alu_op2}, 8'h00);
        check("abort_mode", {4'h0, o_alu_mode}, 8'h00);
        check("abort_done", {7'h0, o_done}, 8'h00);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk);
            #1;
            check($sformatf("abort_nodone%0d", c), {7'h0, o_done}, 8'h00);
        end
        check("abort_ready", {7'h0, o_ready}, 8'h01);
        check_reg("abort_r0", 3'd0, 4'h0);
        check_reg("abort_r1", 3'd1, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
